// File: rtl/tx_almfull_throttle_if.sv
// Merged CCI-P Tx stream types and the interface that carries them between the
// sub-AFU Tx multiplexer, tx_almfull_throttle and the shell.

typedef struct packed {
  logic        valid;
  logic [63:0] hdr;
} t_if_ccip_c0_Tx;

typedef struct packed {
  logic         valid;
  logic [63:0]  hdr;
  logic [511:0] data;
} t_if_ccip_c1_Tx;

// MMIO read response: hdr carries the transaction id.
typedef struct packed {
  logic        valid;
  logic [8:0]  hdr;
  logic [63:0] data;
} t_if_ccip_c2_Tx;

typedef struct packed {
  t_if_ccip_c0_Tx c0;
  t_if_ccip_c1_Tx c1;
  t_if_ccip_c2_Tx c2;
} t_if_ccip_Tx;

interface tx_almfull_throttle_if;
  t_if_ccip_Tx tx;

  // Producer of the stream.
  modport master (output tx);
  // Consumer of the stream.
  modport slave (input tx);
endinterface

// File: rtl/tx_almfull_throttle.sv
// tx_almfull_throttle: buffers merged c0 (read) and c1 (write) requests in
// per-channel FIFOs and releases them to the shell only while the registered
// shell almost-full is low. Raises early per-channel stalls so requests still
// in flight upstream fit in the reserved slack. c2 passes through one register.
// Optional feature: define TX_THROTTLE_STATS_EN to build the stall-cycle
// counters; otherwise c0_stall_cycles / c1_stall_cycles read 0.

module tx_almfull_throttle #(
  parameter int unsigned N_ENTRIES   = 64,
  parameter int unsigned STALL_SLACK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  tx_almfull_throttle_if.slave  in,
  tx_almfull_throttle_if.master out,
  input  logic                  c0TxAlmFull,
  input  logic                  c1TxAlmFull,
  output logic                  c0_stall,
  output logic                  c1_stall,
  output logic                  overflow_err,
  output logic [31:0]           c0_stall_cycles,
  output logic [31:0]           c1_stall_cycles
);

  localparam int unsigned AddrW = $clog2(N_ENTRIES);
  localparam int unsigned OccW  = AddrW + 1;
  localparam logic [OccW-1:0] OccFull   = OccW'(N_ENTRIES);
  localparam logic [OccW-1:0] OccThresh = OccW'(N_ENTRIES - STALL_SLACK);

  // Registered shell almost-full; the only copy the pop logic looks at.
  logic c0_almfull_q, c1_almfull_q;

  // Sample shell almost-full once per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_almfull_q <= 1'b0;
      c1_almfull_q <= 1'b0;
    end else begin
      c0_almfull_q <= c0TxAlmFull;
      c1_almfull_q <= c1TxAlmFull;
    end
  end

  // ---------------------------------------------------------------------------
  // c0 (read request) FIFO
  // ---------------------------------------------------------------------------
  logic [63:0]      c0_mem [N_ENTRIES];
  logic [AddrW-1:0] c0_wr_ptr_q, c0_rd_ptr_q;
  logic [OccW-1:0]  c0_occ_q, c0_occ_d;
  logic             c0_push, c0_pop, c0_drop;

  // Full is judged on the current occupancy, so a same-cycle pop never frees
  // a slot for the incoming request.
  always_comb begin
    c0_push  = in.tx.c0.valid && (c0_occ_q != OccFull);
    c0_drop  = in.tx.c0.valid && (c0_occ_q == OccFull);
    c0_pop   = (c0_occ_q != '0) && !c0_almfull_q;
    c0_occ_d = c0_occ_q;
    if (c0_push && !c0_pop) begin
      c0_occ_d = c0_occ_q + 1'b1;
    end else if (!c0_push && c0_pop) begin
      c0_occ_d = c0_occ_q - 1'b1;
    end
  end

  // c0 storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (c0_push) begin
      c0_mem[c0_wr_ptr_q] <= in.tx.c0.hdr;
    end
  end

  // c0 pointers and occupancy; pointers wrap naturally at N_ENTRIES.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_wr_ptr_q <= '0;
      c0_rd_ptr_q <= '0;
      c0_occ_q    <= '0;
    end else begin
      if (c0_push) c0_wr_ptr_q <= c0_wr_ptr_q + 1'b1;
      if (c0_pop)  c0_rd_ptr_q <= c0_rd_ptr_q + 1'b1;
      c0_occ_q <= c0_occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // c1 (write request) FIFO
  // ---------------------------------------------------------------------------
  logic [63:0]      c1_hdr_mem  [N_ENTRIES];
  logic [511:0]     c1_data_mem [N_ENTRIES];
  logic [AddrW-1:0] c1_wr_ptr_q, c1_rd_ptr_q;
  logic [OccW-1:0]  c1_occ_q, c1_occ_d;
  logic             c1_push, c1_pop, c1_drop;

  // Same policy as c0: full before pop, pop only when non-empty and allowed.
  always_comb begin
    c1_push  = in.tx.c1.valid && (c1_occ_q != OccFull);
    c1_drop  = in.tx.c1.valid && (c1_occ_q == OccFull);
    c1_pop   = (c1_occ_q != '0) && !c1_almfull_q;
    c1_occ_d = c1_occ_q;
    if (c1_push && !c1_pop) begin
      c1_occ_d = c1_occ_q + 1'b1;
    end else if (!c1_push && c1_pop) begin
      c1_occ_d = c1_occ_q - 1'b1;
    end
  end

  // c1 storage for header and data.
  always_ff @(posedge clk) begin
    if (c1_push) begin
      c1_hdr_mem[c1_wr_ptr_q]  <= in.tx.c1.hdr;
      c1_data_mem[c1_wr_ptr_q] <= in.tx.c1.data;
    end
  end

  // c1 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      c1_wr_ptr_q <= '0;
      c1_rd_ptr_q <= '0;
      c1_occ_q    <= '0;
    end else begin
      if (c1_push) c1_wr_ptr_q <= c1_wr_ptr_q + 1'b1;
      if (c1_pop)  c1_rd_ptr_q <= c1_rd_ptr_q + 1'b1;
      c1_occ_q <= c1_occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, stalls and error flag
  // ---------------------------------------------------------------------------
  t_if_ccip_Tx tx_out_q;
  logic        c0_stall_q, c1_stall_q;
  logic        overflow_q;

  // Output stage: popped entries go out with valid set, idle channels are all zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_out_q <= '0;
    end else begin
      if (c0_pop) begin
        tx_out_q.c0.valid <= 1'b1;
        tx_out_q.c0.hdr   <= c0_mem[c0_rd_ptr_q];
      end else begin
        tx_out_q.c0 <= '0;
      end
      if (c1_pop) begin
        tx_out_q.c1.valid <= 1'b1;
        tx_out_q.c1.hdr   <= c1_hdr_mem[c1_rd_ptr_q];
        tx_out_q.c1.data  <= c1_data_mem[c1_rd_ptr_q];
      end else begin
        tx_out_q.c1 <= '0;
      end
      tx_out_q.c2 <= in.tx.c2;
    end
  end

  // Stall tracks the occupancy that will be present next cycle, so it rises
  // the cycle right after the threshold-crossing push.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_stall_q <= 1'b0;
      c1_stall_q <= 1'b0;
    end else begin
      c0_stall_q <= (c0_occ_d >= OccThresh);
      c1_stall_q <= (c1_occ_d >= OccThresh);
    end
  end

  // Sticky overflow: any request dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (c0_drop || c1_drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign out.tx       = tx_out_q;
  assign c0_stall     = c0_stall_q;
  assign c1_stall     = c1_stall_q;
  assign overflow_err = overflow_q;

`ifdef TX_THROTTLE_STATS_EN
  logic [31:0] c0_stall_cnt_q, c1_stall_cnt_q;

  // Saturating stall-cycle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_stall_cnt_q <= '0;
      c1_stall_cnt_q <= '0;
    end else begin
      if (c0_stall_q && (c0_stall_cnt_q != 32'hFFFF_FFFF)) begin
        c0_stall_cnt_q <= c0_stall_cnt_q + 32'd1;
      end
      if (c1_stall_q && (c1_stall_cnt_q != 32'hFFFF_FFFF)) begin
        c1_stall_cnt_q <= c1_stall_cnt_q + 32'd1;
      end
    end
  end

  assign c0_stall_cycles = c0_stall_cnt_q;
  assign c1_stall_cycles = c1_stall_cnt_q;
`else
  assign c0_stall_cycles = '0;
  assign c1_stall_cycles = '0;
`endif

endmodule

// File: doc/tx_almfull_throttle.md
# tx_almfull_throttle

Downstream stage of the sub-AFU Tx multiplexer in the VAI mux: consumes the single merged `t_if_ccip_Tx` stream and forwards it to the shell's CCI-P Tx port while honouring the shell's `c0TxAlmFull`/`c1TxAlmFull`. The multiplexer pipeline cannot stop on a single cycle, so this block buffers c0 (read) and c1 (write) requests in per-channel FIFOs. It raises early per-channel stall signals that the mux fans out as sub-AFU almost-full. c2 (MMIO read responses) is never throttled.

## Interface
Parameters:
- `N_ENTRIES`, 64: depth of each of the c0 and c1 FIFOs; a power of two, ≥ 16.
- `STALL_SLACK`, 8: free entries reserved for requests already in flight upstream when stall asserts; must be < `N_ENTRIES`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  `t_if_ccip_Tx`  merged Tx stream from the multiplexer.
- `out`  out  `t_if_ccip_Tx`  Tx stream to the shell.
- `c0TxAlmFull`  in  1  shell c0 almost-full.
- `c1TxAlmFull`  in  1  shell c1 almost-full.
- `c0_stall`  out  1  upstream must stop issuing c0 requests.
- `c1_stall`  out  1  upstream must stop issuing c1 requests.
- `overflow_err`  out  1  sticky flag: a request arrived while its FIFO was full.
- `c0_stall_cycles`  out  32  count of cycles with `c0_stall` high (see Configuration).
- `c1_stall_cycles`  out  32  count of cycles with `c1_stall` high (see Configuration).

## Operation
- c0 path:
  - `in.c0.valid` high: push `in.c0` (hdr) into the c0 FIFO.
  - Each cycle: if the c0 FIFO is not empty and the registered `c0TxAlmFull` is low, pop one entry into the `out.c0` register with valid = 1.
  - Otherwise `out.c0` = 0.
- c1 path: identical to c0, using the c1 FIFO, `c1TxAlmFull` and `in.c1` (hdr + data).
- c2 path: `out.c2` <= `in.c2` every cycle, one register stage, no buffering.
- Stall: `cN_stall` = registered (occupancy_N ≥ `N_ENTRIES` − `STALL_SLACK`).
- Occupancy counter: width `$clog2(N_ENTRIES)+1`.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
- Full FIFO:
  - An incoming request is dropped and `overflow_err` sets; it stays set until reset.
  - A pop in the same cycle does NOT make room for the push; full is evaluated before the pop.
- Empty FIFO: no pop, out valid = 0, regardless of almFull.
- Pointers wrap modulo `N_ENTRIES`.
- At most one pop per channel per cycle. c0 and c1 pop independently.
- Reset, including mid-operation:
  - Pointers, occupancy, `out` (all fields), `cN_stall`, `overflow_err`, counters and the almFull sample registers all go to 0.
  - Buffered requests are discarded.

## Timing
- In-to-out latency with an empty FIFO and almFull low: 2 cycles. Request valid in cycle T → `out` valid in cycle T+2.
- c2 latency: 1 cycle.
- almFull response:
  - `cNTxAlmFull` sampled high in cycle T → no pop in cycle T+1, so `out` valid is 0 from T+2.
  - Deassert in cycle T → pops resume in T+1, with `out` valid in T+2.
- Stall response: the occupancy threshold crossed at the end of cycle T → `cN_stall` high in cycle T+1.
- Stall deassert: first cycle after occupancy drops below the threshold, plus 1 register.
- Throughput: one request per channel per cycle sustained while almFull stays low.

## Configuration
- `TX_THROTTLE_STATS_EN` defined:
  - `c0_stall_cycles` / `c1_stall_cycles` are 32-bit counters, incremented each cycle the matching `cN_stall` is high.
  - They saturate at 0xFFFFFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Single c0 read in cycle 10, almFull low → `out.c0.valid` = 1 in cycle 12 only, with hdr equal to the input; `out.c1.valid` = 0.
- `c1TxAlmFull` high for 20 cycles while 10 c1 writes arrive on consecutive cycles → no `out.c1.valid` during the window. After deassert: 10 back-to-back outputs, in order, with matching data; occupancy returns to 0.
- `N_ENTRIES`=64, `STALL_SLACK`=8, `c0TxAlmFull` held high, 56 pushes → `c0_stall` = 1 the cycle after the 56th push. After 8 more pushes (full), a 65th push → dropped and `overflow_err` = 1.
- Simultaneous push and pop at occupancy 5 → occupancy stays 5. Push and pop on an empty FIFO → the request emerges 2 cycles later with no loss.
- `reset` asserted with 30 c0 entries buffered → next cycle `out` = 0, stalls = 0, `overflow_err` = 0. After release, no stale request ever appears.
- With `TX_THROTTLE_STATS_EN` defined, hold `c1_stall` high 100 cycles → `c1_stall_cycles` = 100. Undefined → it reads 0.
